// File: rtl/vector_operand_loader.sv
// vector_operand_loader: packs a serial 32-bit element stream into two
// N-lane operand banks (A then B) and presents them as a held pair.
//
// Ports:
//   clk, rst_n          rising-edge clock, async active-low reset
//   in_valid/in_ready   element stream handshake, in_data payload
//   in_last             framing marker (checked only with the macro)
//   a[N], b[N]          operand banks A and B
//   vec_valid/vec_ready operand pair handshake
//   fill_idx            next slot index within the bank being filled
//   frame_err           sticky framing error
//
// Optional feature macro: VLOAD_LAST_CHECK_EN enables the in_last
// framing check; without it frame_err is tied to 0.

module vector_operand_loader #(
    parameter int N = 16,
    localparam int CW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   in_data,
    input  logic          in_last,
    output logic [31:0]   a [N],
    output logic [31:0]   b [N],
    output logic          vec_valid,
    input  logic          vec_ready,
    output logic [CW-1:0] fill_idx,
    output logic          frame_err
);

    typedef enum logic [1:0] {
        FILL_A,
        FILL_B,
        HOLD
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] idx_nxt;
    logic          vv_nxt;
    logic          accept;
    logic          last_slot;

    assign last_slot = (fill_idx == CW'(N - 1));
    assign accept    = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FILL_A;
            fill_idx  <= '0;
            vec_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            fill_idx  <= idx_nxt;
            vec_valid <= vv_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = fill_idx;
        vv_nxt    = vec_valid;
        in_ready  = 1'b0;
        unique case (state)
            FILL_A: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (last_slot) begin
                        idx_nxt   = '0;
                        state_nxt = FILL_B;
                    end else begin
                        idx_nxt = fill_idx + 1'b1;
                    end
                end
            end
            FILL_B: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (last_slot) begin
                        idx_nxt   = '0;
                        state_nxt = HOLD;
                        vv_nxt    = 1'b1;
                    end else begin
                        idx_nxt = fill_idx + 1'b1;
                    end
                end
            end
            HOLD: begin
                // handshake cycle accepts no element; refill starts next cycle
                if (vec_ready) begin
                    vv_nxt    = 1'b0;
                    state_nxt = FILL_A;
                end
            end
            default: begin
                state_nxt = FILL_A;
            end
        endcase
    end

    // banks are never cleared between vectors, only overwritten slot by slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                a[i] <= '0;
                b[i] <= '0;
            end
        end else if (accept) begin
            for (int i = 0; i < N; i++) begin
                if (fill_idx == CW'(i)) begin
                    if (state == FILL_A) begin
                        a[i] <= in_data;
                    end else begin
                        b[i] <= in_data;
                    end
                end
            end
        end
    end

`ifdef VLOAD_LAST_CHECK_EN
    logic last_exp;

    // in_last must be set exactly on the final element of bank B
    assign last_exp = (state == FILL_B) && last_slot;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err <= 1'b0;
        end else if (accept && (in_last != last_exp)) begin
            frame_err <= 1'b1;
        end
    end
`else
    logic unused_last;

    assign unused_last = in_last;
    assign frame_err   = 1'b0;
`endif

endmodule

// File: tb/tb_vector_operand_loader.sv
// tb_vector_operand_loader: directed checks of vector_operand_loader
// at N=4, N=16 and N=1.

module tb_vector_operand_loader;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef VLOAD_LAST_CHECK_EN
    localparam logic FE = 1'b1;
`else
    localparam logic FE = 1'b0;
`endif

    // N=4 instance
    logic        v4 = 0, l4 = 0, r4 = 0, ir4, vv4, fe4;
    logic [31:0] d4 = 0;
    logic [31:0] a4 [4];
    logic [31:0] b4 [4];
    logic [1:0]  fi4;

    vector_operand_loader #(.N(4)) u4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(v4), .in_ready(ir4), .in_data(d4), .in_last(l4),
        .a(a4), .b(b4), .vec_valid(vv4), .vec_ready(r4),
        .fill_idx(fi4), .frame_err(fe4)
    );

    // N=16 instance
    logic        v16 = 0, r16 = 0, ir16, vv16, fe16;
    logic [31:0] d16 = 0;
    logic [31:0] a16 [16];
    logic [31:0] b16 [16];
    logic [3:0]  fi16;

    vector_operand_loader #(.N(16)) u16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(v16), .in_ready(ir16), .in_data(d16), .in_last(1'b0),
        .a(a16), .b(b16), .vec_valid(vv16), .vec_ready(r16),
        .fill_idx(fi16), .frame_err(fe16)
    );

    // N=1 instance
    logic        v1 = 0, r1 = 0, ir1, vv1, fe1;
    logic [31:0] d1 = 0;
    logic [31:0] a1 [1];
    logic [31:0] b1 [1];
    logic [0:0]  fi1;

    vector_operand_loader #(.N(1)) u1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(v1), .in_ready(ir1), .in_data(d1), .in_last(1'b0),
        .a(a1), .b(b1), .vec_valid(vv1), .vec_ready(r1),
        .fill_idx(fi1), .frame_err(fe1)
    );

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // eight back-to-back elements base..base+7 into the N=4 loader
    task automatic stream4(input logic [31:0] base, input int lastpos);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 7) check("pre_valid4", 32'(vv4), 32'd0);
            v4 = 1'b1;
            d4 = base + 32'(i);
            l4 = (i == lastpos);
            @(posedge clk);
        end
        @(negedge clk);
        v4 = 1'b0;
        l4 = 1'b0;
        check("valid4", 32'(vv4), 32'd1);
        check("ready4_hold", 32'(ir4), 32'd0);
        check("idx4_hold", 32'(fi4), 32'd0);
        for (int k = 0; k < 4; k++) begin
            check("a4", a4[k], base + 32'(k));
            check("b4", b4[k], base + 32'(k + 4));
        end
    endtask

    task automatic hs4();
        @(negedge clk);
        r4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        r4 = 1'b0;
        check("hs_valid4", 32'(vv4), 32'd0);
        check("hs_ready4", 32'(ir4), 32'd1);
    endtask

    initial begin
        int acc;
        int cyc;
        int hi;
        logic early;

        // reset state
        #12;
        check("rst_idx4", 32'(fi4), 32'd0);
        check("rst_valid4", 32'(vv4), 32'd0);
        check("rst_a4", a4[0], 32'd0);
        check("rst_b4", b4[3], 32'd0);
        check("rst_fe4", 32'(fe4), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready4", 32'(ir4), 32'd1);

        // 1: stream 1..8, hold 10 cycles with vec_ready low
        stream4(32'd1, 7);
        v4 = 1'b1;
        d4 = 32'd99;
        repeat (10) @(negedge clk);
        v4 = 1'b0;
        check("hold_ready4", 32'(ir4), 32'd0);
        check("hold_valid4", 32'(vv4), 32'd1);
        check("hold_a4", a4[0], 32'd1);
        check("hold_b4", b4[3], 32'd8);

        // 2: handshake then 9..16
        hs4();
        stream4(32'd9, 7);
        check("fe4_ok", 32'(fe4), 32'd0);

        // 6a: in_last on element 3, then a correct vector
        hs4();
        stream4(32'd17, 2);
        check("fe4_bad", 32'(fe4), 32'(FE));
        hs4();
        stream4(32'd25, 7);
        check("fe4_sticky", 32'(fe4), 32'(FE));

        // 3: N=16 with random gaps, data = accept index * 3
        acc = 0;
        cyc = 0;
        early = 1'b0;
        while (acc < 32 && cyc < 1000) begin
            @(negedge clk);
            check("idx16", 32'(fi16), 32'(acc % 16));
            early = early | vv16;
            v16 = 1'($urandom_range(0, 1));
            d16 = 32'(acc * 3);
            @(posedge clk);
            if (v16 && ir16) acc++;
            cyc++;
        end
        check("acc16_bound", 32'(acc), 32'd32);
        @(negedge clk);
        v16 = 1'b0;
        check("early16", 32'(early), 32'd0);
        check("valid16", 32'(vv16), 32'd1);
        for (int k = 0; k < 16; k++) begin
            check("a16", a16[k], 32'(3 * k));
            check("b16", b16[k], 32'(3 * (k + 16)));
        end

        // 5: N=1 with vec_ready held high
        r1 = 1'b1;
        @(negedge clk);
        v1 = 1'b1;
        d1 = 32'hDEADBEEF;
        @(posedge clk);
        @(negedge clk);
        d1 = 32'h12345678;
        @(posedge clk);
        @(negedge clk);
        check("valid1", 32'(vv1), 32'd1);
        check("a1", a1[0], 32'hDEADBEEF);
        check("b1", b1[0], 32'h12345678);
        check("idx1", 32'(fi1), 32'd0);
        d1 = 32'h7;
        hi = 0;
        repeat (9) begin
            @(negedge clk);
            if (vv1) hi++;
        end
        v1 = 1'b0;
        check("period1", 32'(hi), 32'd3);
        check("b1_last", b1[0], 32'h7);

        // 4: async reset after 6 accepts on N=4
        hs4();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            v4 = 1'b1;
            d4 = 32'd50 + 32'(i);
            @(posedge clk);
        end
        @(negedge clk);
        v4 = 1'b0;
        check("mid_idx4", 32'(fi4), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_idx4", 32'(fi4), 32'd0);
        check("arst_a4", a4[0], 32'd0);
        check("arst_b4", b4[1], 32'd0);
        check("arst_valid4", 32'(vv4), 32'd0);
        check("arst_fe4", 32'(fe4), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        stream4(32'd100, 7);
        check("fe4_clean", 32'(fe4), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
